// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE stream feeder.
//   state_e    : feeder FSM states
//   SKID_DEPTH : entries in the read-data skid FIFO
//   RD_LATENCY : buffer read latency in cycles (the datapath assumes 1)
package pe_feeder_pkg;
  typedef enum logic [1:0] {IDLE, START, STREAM, FINISH} state_e;
  localparam int SKID_DEPTH = 2;
  localparam int RD_LATENCY = 1;
endpackage

// File: rtl/pe_stream_feeder_if.sv
// Bundle between the feeder and its neighbours: the command channel, the
// local buffer read port and the PE input-FIFO port.
//   master : the feeder side (drives cmd_ready, buffer read, PE data)
//   slave  : the environment side (controller, buffer, PE)
interface pe_stream_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  cmd_full_column;
  logic                  buf_rd_en;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic                  pe_start_load;
  logic                  pe_load_full_column;
  logic [DATA_WIDTH-1:0] pe_data;
  logic                  pe_data_en;
  logic                  pe_fifo_full;

  modport master (
    input  cmd_valid, cmd_base_addr, cmd_len, cmd_full_column, buf_rd_data, pe_fifo_full,
    output cmd_ready, buf_rd_en, buf_rd_addr, pe_start_load, pe_load_full_column,
           pe_data, pe_data_en
  );
  modport slave (
    output cmd_valid, cmd_base_addr, cmd_len, cmd_full_column, buf_rd_data, pe_fifo_full,
    input  cmd_ready, buf_rd_en, buf_rd_addr, pe_start_load, pe_load_full_column,
           pe_data, pe_data_en
  );
endinterface

// File: rtl/pe_feeder_skid_fifo.sv
// Two-entry skid FIFO holding buffer read data until the output register
// takes it.
//   clk, rst : clock, async active-low reset
//   push/din : write din this cycle
//   pop      : drop the head entry this cycle (only when count != 0)
//   head     : oldest entry
//   count    : occupancy, 0..2
module pe_feeder_skid_fifo
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);
  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                                  wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/pe_stream_feeder.sv
// Streams a contiguous, wrapping address range out of a local single-port
// buffer into one PE input FIFO. Each command gives a start-load pulse, then
// len words with pe_fifo_full backpressure, then a one-cycle done.
//   clk, rst     : clock, async active-low reset
//   bus (master) : command channel, buffer read port, PE port
//   busy         : high from the cycle after accept through the done cycle
//   done         : one-cycle pulse one cycle after the last transfer
//   stall_cycles : only with PE_FEEDER_STALL_CNT_EN defined; saturating
//                  count of cycles with pe_data_en=1 and pe_fifo_full=1
module pe_stream_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  pe_stream_feeder_if.master bus,
  output logic               busy,
  output logic               done
`ifdef PE_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);
  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q, issued, sent;
  logic                  full_col_q;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_en_q;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [1:0]            skid_cnt;
  logic [2:0]            occ;
  logic                  accept, xfer, last_xfer, load, rd_en;

  assign accept    = bus.cmd_valid & bus.cmd_ready;
  assign xfer      = data_en_q & ~bus.pe_fifo_full;
  assign last_xfer = xfer && (sent == len_q - LEN_WIDTH'(1));
  // Output register refills when empty or when its word leaves this cycle.
  assign load      = (state == STREAM) && (skid_cnt != 2'd0) && (!data_en_q || xfer);
  // Occupancy is taken after this cycle's pop; counting the entry that is
  // leaving would cost a bubble every other word.
  assign occ       = 3'(skid_cnt) - 3'(load) + 3'(rd_inflight);
  assign rd_en     = ((state == START) || (state == STREAM)) &&
                     (issued < len_q) && (occ < 3'(SKID_DEPTH));

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = (len_q == '0) ? FINISH : STREAM;
      STREAM:  if (last_xfer) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // cmd_ready is gated by rst so it stays low while reset is held.
  always_comb begin
    bus.cmd_ready     = 1'b0;
    bus.pe_start_load = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    case (state)
      IDLE:   bus.cmd_ready = rst;
      START:  begin busy = 1'b1; bus.pe_start_load = 1'b1; end
      STREAM: busy = 1'b1;
      FINISH: begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // ---- datapath: command latch, counters, output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q      <= '0;
      len_q       <= '0;
      full_col_q  <= 1'b0;
      issued      <= '0;
      sent        <= '0;
      rd_inflight <= 1'b0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
    end else begin
      rd_inflight <= rd_en;
      if (accept) begin
        base_q     <= bus.cmd_base_addr;
        len_q      <= bus.cmd_len;
        full_col_q <= bus.cmd_full_column;
        issued     <= '0;
        sent       <= '0;
      end else begin
        if (rd_en) issued <= issued + LEN_WIDTH'(1);
        if (xfer)  sent   <= sent + LEN_WIDTH'(1);
      end
      if (load) begin
        data_q    <= skid_head;
        data_en_q <= 1'b1;
      end else if (xfer) begin
        data_en_q <= 1'b0;
      end
    end
  end

  // Read data lands one cycle after the strobe; rd_inflight marks it.
  pe_feeder_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_inflight),
    .din   (bus.buf_rd_data),
    .pop   (load),
    .head  (skid_head),
    .count (skid_cnt)
  );

  assign bus.buf_rd_en           = rd_en;
  assign bus.buf_rd_addr         = base_q + ADDR_WIDTH'(issued);
  assign bus.pe_data             = data_q;
  assign bus.pe_data_en          = data_en_q;
  assign bus.pe_load_full_column = full_col_q;

`ifdef PE_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         stall_cycles <= '0;
    else if (accept)                                  stall_cycles <= '0;
    else if (data_en_q && bus.pe_fifo_full && (stall_cycles != 16'hFFFF))
                                                      stall_cycles <= stall_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pe_stream_feeder.sv
module tb_pe_stream_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy, done;
`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif
  int checks   = 0;
  int failures = 0;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  pe_stream_feeder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) bus ();

  pe_stream_feeder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Buffer model: data valid the cycle after the strobe.
  always @(posedge clk) if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},   32'(bus.buf_rd_en), 0);
    check({tag, "_start"},   32'(bus.pe_start_load), 0);
    check({tag, "_fullcol"}, 32'(bus.pe_load_full_column), 0);
    check({tag, "_data"},    32'(bus.pe_data), 0);
    check({tag, "_data_en"}, 32'(bus.pe_data_en), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_done"},    32'(done), 0);
`ifdef PE_FEEDER_STALL_CNT_EN
    check({tag, "_stall"},   32'(stall_cycles), 0);
`endif
  endtask

  // mode: 0 never full, 1 full on stream cycles 2..5, 2 random, 3 toggling
  // abort_after: >0 asserts reset right after that many transfers
  // junk: hold a bogus cmd_valid while the burst is in progress
  task automatic run_cmd(input logic [7:0] base, input logic [7:0] len, input logic fc,
                         input int mode, input int abort_after, input bit junk);
    logic [15:0] q[$];
    int c = 0, first_en = 0, start_cnt = 0, start_cyc = 0;
    int done_cnt = 0, done_cyc = 0, last_xfer = 0, issued = 0, xfers = 0, stalls = 0;
    bit fin = 0, held_valid = 0;
    logic [15:0] held = '0;
    for (int i = 0; i < int'(len); i++) q.push_back(mem[8'(base + 8'(i))]);

    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_base_addr = base; bus.cmd_len = len;
    bus.cmd_full_column = fc;
    #1 check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    @(posedge clk);  // accept edge

    while (!fin && c < 2000) begin
      c++;
      #1;
      if (bus.pe_data_en && first_en == 0) first_en = c;
      case (mode)
        1: bus.pe_fifo_full = (first_en != 0) && (c - first_en + 1 >= 2) && (c - first_en + 1 <= 5);
        2: bus.pe_fifo_full = 1'($urandom_range(0, 1));
        3: bus.pe_fifo_full = 1'(c % 2);
        default: bus.pe_fifo_full = 1'b0;
      endcase
      bus.cmd_valid = junk && (q.size() != 0);
      if (bus.cmd_valid) begin
        bus.cmd_base_addr = 8'($urandom); bus.cmd_len = 8'($urandom); bus.cmd_full_column = ~fc;
      end
      #1;
      check("busy_during", 32'(busy), 1);
      if (bus.cmd_valid) check("ready_while_busy", 32'(bus.cmd_ready), 0);
      if (bus.pe_start_load) begin start_cnt++; start_cyc = c; end
      if (bus.buf_rd_en) begin
        check("rd_addr", 32'(bus.buf_rd_addr), 32'(8'(base + 8'(issued))));
        issued++;
      end
      if (bus.pe_data_en) begin
        if (held_valid) check("hold_while_full", 32'(bus.pe_data), 32'(held));
        if (bus.pe_fifo_full) begin
          held_valid = 1; held = bus.pe_data; stalls++;
        end else begin
          held_valid = 0;
          if (q.size() == 0) check("extra_word", 32'(bus.pe_data), 32'hDEAD_BEEF);
          else               check("data_order", 32'(bus.pe_data), 32'(q.pop_front()));
          xfers++; last_xfer = c;
        end
      end else held_valid = 0;
      if (done) begin done_cnt++; done_cyc = c; fin = 1; end
      if (abort_after > 0 && xfers == abort_after) begin
        rst = 1'b0;
        #1 check_outputs_zero("abort");
        return;
      end
      if (!fin) @(posedge clk);
    end

    check("done_seen", 32'(fin), 1);
    check("done_count", 32'(done_cnt), 1);
    check("start_count", 32'(start_cnt), 1);
    check("start_cycle", 32'(start_cyc), 1);
    check("words_left", 32'(q.size()), 0);
    check("reads_issued", 32'(issued), 32'(len));
    if (len != 0) begin
      check("first_en_latency", 32'(first_en), 32'(start_cyc + 3));
      check("done_after_last", 32'(done_cyc), 32'(last_xfer + 1));
      if (mode == 0) check("throughput", 32'(last_xfer), 32'(first_en + int'(len) - 1));
    end else begin
      check("no_data_en", 32'(first_en), 0);
      check("done_len0", 32'(done_cyc), 2);
    end
    @(posedge clk); #1;
    bus.pe_fifo_full = 1'b0;
    #1;
    check("busy_after", 32'(busy), 0);
    check("done_once", 32'(done), 0);
    check("data_en_after", 32'(bus.pe_data_en), 0);
    check("ready_after", 32'(bus.cmd_ready), 1);
    check("full_column", 32'(bus.pe_load_full_column), 32'(fc));
`ifdef PE_FEEDER_STALL_CNT_EN
    check("stall_cycles", 32'(stall_cycles), 32'(stalls));
`endif
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_base_addr = '0; bus.cmd_len = '0;
    bus.cmd_full_column = 1'b0; bus.pe_fifo_full = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);

    #3 check_outputs_zero("reset");
    #9 rst = 1'b1;
    #1 check("ready_after_reset", 32'(bus.cmd_ready), 1);

    run_cmd(8'h10, 8'd6, 1'b1, 0, 0, 1'b0);   // plain burst
    run_cmd(8'h10, 8'd6, 1'b0, 1, 0, 1'b1);   // stall cycles 2..5, junk cmd
    run_cmd(8'h33, 8'd0, 1'b1, 0, 0, 1'b0);   // zero length
    run_cmd(8'hFE, 8'd4, 1'b0, 3, 0, 1'b0);   // address wrap, toggling full

    run_cmd(8'h40, 8'd10, 1'b1, 0, 3, 1'b0);  // reset mid-burst
    bus.cmd_valid = 1'b0;
    bus.pe_fifo_full = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("no_done_in_reset", 32'(done), 0);
    end
    rst = 1'b1;
    run_cmd(8'h20, 8'd2, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    run_cmd(8'($urandom), 8'd255, 1'($urandom), 2, 0, 1'b1);
    for (int k = 0; k < 4; k++)
      run_cmd(8'($urandom), 8'($urandom_range(1, 20)), 1'($urandom), 2 + (k % 2), 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
